// File: rtl/regfile_arbiter.sv
// Round-robin arbiter sharing one single-port register file among NREQ requesters,
// plus a bulk-clear sequencer that zeroes every word.
module regfile_arbiter #(
  parameter int Bits = 8,
  parameter int Bus  = 2,
  parameter int NREQ = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_we,
  input  logic [NREQ*Bus-1:0]  req_addr,
  input  logic [NREQ*Bits-1:0] req_wdata,
  output logic [NREQ-1:0]      ack,
  output logic [Bits-1:0]      rdata,
  input  logic                 clear_start,
  output logic                 clear_done,
  output logic                 busy,
  output logic                 rf_we,
  output logic [Bus-1:0]       rf_a,
  output logic [Bits-1:0]      rf_wd,
  input  logic [Bits-1:0]      rf_rd
);
  localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int DEPTH = 2 ** Bus;

  typedef enum logic [1:0] {IDLE, ACCESS, CLEAR} state_t;

  state_t                     state, state_nxt;
  logic [PW-1:0]              ptr, win_idx, grant_idx;
  logic                       grant_vld;
  logic [NREQ-1:0]            elig;
  logic [NREQ-1:0][Bus-1:0]   addr_v;
  logic [NREQ-1:0][Bits-1:0]  wdata_v;
  logic                       lat_we;
  logic [Bus-1:0]             lat_addr;
  logic [Bits-1:0]            lat_wdata;
  logic [Bus-1:0]             cnt;
  logic                       cnt_last;

  assign addr_v   = req_addr;
  assign wdata_v  = req_wdata;
  // The requester being acked this cycle still holds req; masking it prevents a double grant.
  assign elig     = req & ~ack;
  assign cnt_last = (cnt == Bus'(DEPTH - 1));
  assign busy     = (state != IDLE);

  // Walk from the highest offset down so the offset closest to ptr wins.
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (elig[idx]) begin
        grant_vld = 1'b1;
        grant_idx = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clear_start)    state_nxt = CLEAR;
               else if (grant_vld) state_nxt = ACCESS;
      ACCESS:  state_nxt = IDLE;
      CLEAR:   if (cnt_last)       state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rf_we = 1'b0;
    rf_a  = '0;
    rf_wd = '0;
    case (state)
      ACCESS: begin
        rf_we = lat_we;
        rf_a  = lat_addr;
        rf_wd = lat_we ? lat_wdata : '0;
      end
      CLEAR: begin
        rf_we = 1'b1;
        rf_a  = cnt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr        <= '0;
      win_idx    <= '0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      ack        <= '0;
      rdata      <= '0;
      clear_done <= 1'b0;
      cnt        <= '0;
    end else begin
      ack        <= '0;
      clear_done <= 1'b0;
      case (state)
        IDLE: if (!clear_start && grant_vld) begin
          win_idx   <= grant_idx;
          lat_we    <= req_we[grant_idx];
          lat_addr  <= addr_v[grant_idx];
          lat_wdata <= wdata_v[grant_idx];
          ptr       <= (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end
        ACCESS: begin
          ack          <= '0;
          ack[win_idx] <= 1'b1;
          rdata        <= rf_rd;
        end
        CLEAR: begin
          cnt        <= cnt_last ? '0 : cnt + 1'b1;
          clear_done <= cnt_last;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter: table-driven single accesses plus
// hand-written contention, clear and reset sequences against a behavioural register file.
module tb_regfile_arbiter;
  logic        clk, reset;
  logic [3:0]  req, req_we, ack;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic [7:0]  rdata, rf_wd, rf_rd;
  logic        clear_start, clear_done, busy, rf_we;
  logic [1:0]  rf_a;
  logic [7:0]  mem [4];
  logic        mem_load;
  int          errors, checks;

  regfile_arbiter #(.Bits(8), .Bus(2), .NREQ(4)) dut (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .ack(ack), .rdata(rdata), .clear_start(clear_start),
    .clear_done(clear_done), .busy(busy), .rf_we(rf_we), .rf_a(rf_a), .rf_wd(rf_wd),
    .rf_rd(rf_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_load) for (int i = 0; i < 4; i++) mem[i] <= 8'h10 + 8'(i);
    else if (rf_we) mem[rf_a] <= rf_wd;
  end
  assign rf_rd = mem[rf_a];

  typedef struct {
    int         id;
    logic       we;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One request from requester id; checks the ACCESS-cycle file drive, latency, ack and rdata.
  task automatic access(input int id, input logic we, input logic [1:0] addr,
                        input logic [7:0] wdata, input logic [7:0] exp_rd);
    int lat;
    lat = 0;
    req_we[id] = we;
    req_addr[id*2 +: 2] = addr;
    req_wdata[id*8 +: 8] = wdata;
    req[id] = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("acc_busy", 32'(busy), 1);
        chk("acc_rf_a", 32'(rf_a), 32'(addr));
        chk("acc_rf_we", 32'(rf_we), 32'(we));
        chk("acc_rf_wd", 32'(rf_wd), we ? 32'(wdata) : 0);
      end
      if (ack != 0) begin lat = c; break; end
    end
    chk("acc_latency", lat, 2);
    chk("acc_ack", 32'(ack), 32'(4'b1 << id));
    chk("acc_rdata", 32'(rdata), 32'(exp_rd));
    req[id] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n, we_cyc, done_cyc, ack_cyc, seen;
    int   t_ack[5];
    logic [3:0] a_v[5];
    logic [7:0] r_v[5];
    logic [3:0] exp_ack[5];
    logic [7:0] exp_rd[5];

    errors = 0; checks = 0;
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0; clear_start = 1'b0;
    reset = 1'b1; mem_load = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(clear_done), 0);
    chk("rst_rf_we", 32'(rf_we), 0);
    chk("rst_rf_a", 32'(rf_a), 0);
    reset = 1'b0; mem_load = 1'b0;
    @(negedge clk);

    // Contention: all four hold read requests; expect 0,1,2,3,0 every 2 cycles.
    exp_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_rd  = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    req_addr = {2'd3, 2'd2, 2'd1, 2'd0};
    req = 4'hF;
    n = 0;
    for (int c = 1; c <= 20 && n < 5; c++) begin
      @(negedge clk);
      if (ack != 0) begin t_ack[n] = c; a_v[n] = ack; r_v[n] = rdata; n++; end
    end
    req = '0;
    @(negedge clk);
    chk("cont_count", n, 5);
    for (int i = 0; i < n; i++) begin
      chk("cont_ack", 32'(a_v[i]), 32'(exp_ack[i]));
      chk("cont_rdata", 32'(r_v[i]), 32'(exp_rd[i]));
      if (i > 0) chk("cont_gap", t_ack[i] - t_ack[i-1], 2);
    end

    // Memory now 10,11,12,13.
    vecs[0] = '{1, 1'b0, 2'd2, 8'h00, 8'h12};
    vecs[1] = '{0, 1'b1, 2'd3, 8'hC3, 8'h13};
    vecs[2] = '{0, 1'b0, 2'd3, 8'h00, 8'hC3};
    vecs[3] = '{2, 1'b1, 2'd2, 8'h5A, 8'h12};
    vecs[4] = '{1, 1'b0, 2'd2, 8'h00, 8'h5A};
    vecs[5] = '{3, 1'b1, 2'd0, 8'hFF, 8'h10};
    vecs[6] = '{2, 1'b1, 2'd1, 8'hFF, 8'h11};
    vecs[7] = '{1, 1'b1, 2'd2, 8'hFF, 8'h5A};
    vecs[8] = '{0, 1'b1, 2'd3, 8'hFF, 8'hC3};
    vecs[9] = '{3, 1'b0, 2'd0, 8'h00, 8'hFF};
    for (int v = 0; v < 10; v++)
      access(vecs[v].id, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].exp_rdata);

    // Bulk clear: 4 busy cycles writing 0 to addresses 0..3, then a 1-cycle done pulse.
    clear_start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      clear_start = 1'b0;
      chk("clr_busy", 32'(busy), 1);
      chk("clr_rf_we", 32'(rf_we), 1);
      chk("clr_rf_a", 32'(rf_a), k);
      chk("clr_rf_wd", 32'(rf_wd), 0);
    end
    @(negedge clk);
    chk("clr_end_busy", 32'(busy), 0);
    chk("clr_done", 32'(clear_done), 1);
    @(negedge clk);
    chk("clr_done_pulse", 32'(clear_done), 0);
    for (int k = 0; k < 4; k++) access(k, 1'b0, 2'(k), 8'h00, 8'h00);

    // Clear beats a simultaneous req[2]; a second clear_start during CLEAR is ignored.
    access(3, 1'b1, 2'd1, 8'h66, 8'h00);
    req_we[2] = 1'b0; req_addr[5:4] = 2'd1;
    clear_start = 1'b1; req[2] = 1'b1;
    we_cyc = 0; done_cyc = 0; ack_cyc = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      clear_start = (c == 2);
      if (rf_we) we_cyc++;
      if (clear_done) done_cyc = c;
      if (ack != 0) begin ack_cyc = c; break; end
    end
    chk("prio_we_cycles", we_cyc, 4);
    chk("prio_done_cyc", done_cyc, 5);
    chk("prio_ack_cyc", ack_cyc, 7);
    chk("prio_ack", 32'(ack), 32'(4'b0100));
    chk("prio_rdata", 32'(rdata), 0);
    req = '0;
    @(negedge clk);

    // Async reset in the middle of an ACCESS write.
    access(2, 1'b1, 2'd1, 8'h3C, 8'h00);
    access(3, 1'b0, 2'd1, 8'h00, 8'h3C);
    req_we[0] = 1'b1; req_addr[1:0] = 2'd1; req_wdata[7:0] = 8'h77; req[0] = 1'b1;
    @(negedge clk);
    chk("racc_busy_before", 32'(busy), 1);
    #2 reset = 1'b1;
    #1;
    chk("racc_busy", 32'(busy), 0);
    chk("racc_ack", 32'(ack), 0);
    chk("racc_rdata", 32'(rdata), 0);
    chk("racc_rf_we", 32'(rf_we), 0);
    @(negedge clk);
    req = '0; reset = 1'b0;
    seen = 0;
    repeat (4) begin @(negedge clk); if (ack != 0 || busy) seen++; end
    chk("racc_quiet", seen, 0);
    chk("racc_mem_kept", 32'(mem[1]), 32'h3C);

    // Async reset during CLEAR at counter 1.
    clear_start = 1'b1;
    @(negedge clk);
    clear_start = 1'b0;
    @(negedge clk);
    chk("rclr_rf_a_before", 32'(rf_a), 1);
    #2 reset = 1'b1;
    #1;
    chk("rclr_busy", 32'(busy), 0);
    chk("rclr_rf_we", 32'(rf_we), 0);
    chk("rclr_rf_a", 32'(rf_a), 0);
    chk("rclr_done", 32'(clear_done), 0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (6) begin @(negedge clk); if (clear_done || busy) seen++; end
    chk("rclr_quiet", seen, 0);
    chk("rclr_mem0", 32'(mem[0]), 0);
    access(1, 1'b0, 2'd1, 8'h00, 8'h3C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
